port_ingress_buf: RTL and testbench

Per-port ingress queue between a switch port's packet interface and the switch core's routing/arbitration logic. Accepts {source, target, data} packets on a valid/ready handshake, optionally filters malformed packets, buffers up to DEPTH packets in FIFO order and presents them first-word-fall-through to the core. There is one instance per port, four in the 4-port switch.

---
 rtl/port_ingress_buf.sv | 94 +++++++++
 tb/tb_port_ingress_buf.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/port_ingress_buf.sv
// Per-port ingress FIFO: valid/ready packet intake, optional malformed-packet filter,
// first-word-fall-through egress to the switch core. Filter enabled by PORT_INGRESS_FILTER_EN.
module port_ingress_buf #(
  parameter int          DEPTH   = 4,
  parameter logic [3:0]  PORT_ID = 4'b0001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [3:0]                   source_in,
  input  logic [3:0]                   target_in,
  input  logic [7:0]                   data_in,
  output logic                         ready,
  output logic                         fwd_valid,
  output logic [3:0]                   fwd_source,
  output logic [3:0]                   fwd_target,
  output logic [7:0]                   fwd_data,
  input  logic                         fwd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [7:0]                   drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
  } pkt_t;

  pkt_t            mem_q [DEPTH];
  pkt_t            head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            accept, drop, push, pop;

  // Handshake qualifiers come only from registered occupancy, never from valid_in.
  assign ready     = (count_q != CW'(DEPTH));
  assign fwd_valid = (count_q != '0);
  assign accept    = valid_in && ready;
  assign push      = accept && !drop;
  assign pop       = fwd_valid && fwd_ready;

`ifdef PORT_INGRESS_FILTER_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop = (source_in != PORT_ID) || !$onehot(target_in) || (target_in == PORT_ID);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop     = 1'b0;
  assign drop_cnt = 8'd0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; gating on rst_n keeps a reset-cycle packet out.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= '{src: source_in, tgt: target_in, data: data_in};
  end

  assign head       = mem_q[rd_ptr_q];
  assign fwd_source = head.src;
  assign fwd_target = head.tgt;
  assign fwd_data   = head.data;
  assign count      = count_q;

endmodule

// File: tb/tb_port_ingress_buf.sv
// Scoreboard bench for port_ingress_buf; expectations follow PORT_INGRESS_FILTER_EN when defined.
module tb_port_ingress_buf;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [3:0]    source_in = '0, target_in = '0;
  logic [7:0]    data_in = '0;
  logic          ready, fwd_valid, fwd_ready = 1'b0;
  logic [3:0]    fwd_source, fwd_target;
  logic [7:0]    fwd_data;
  logic [CW-1:0] count;
  logic [7:0]    drop_cnt;

  int            ntests = 0, nfail = 0;
  logic [15:0]   sb[$];

  port_ingress_buf #(.DEPTH(4), .PORT_ID(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .source_in(source_in),
    .target_in(target_in), .data_in(data_in), .ready(ready), .fwd_valid(fwd_valid),
    .fwd_source(fwd_source), .fwd_target(fwd_target), .fwd_data(fwd_data),
    .fwd_ready(fwd_ready), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_drop(logic [3:0] s, logic [3:0] t);
`ifdef PORT_INGRESS_FILTER_EN
    return (s != 4'b0001) || !$onehot(t) || (t == 4'b0001);
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock: record handshakes seen before the edge, then return at the next negedge.
  task automatic step();
    logic [15:0] exp;
    if (!rst_n) sb.delete();
    else begin
      if (fwd_valid && fwd_ready) begin
        ntests++;
        if (sb.size() == 0) begin
          nfail++; $display("FAIL sb_underflow: got pkt %h, want none", {fwd_source, fwd_target, fwd_data});
        end else begin
          exp = sb.pop_front();
          if ({fwd_source, fwd_target, fwd_data} !== exp) begin
            nfail++; $display("FAIL sb_order: got %h want %h", {fwd_source, fwd_target, fwd_data}, exp);
          end
        end
      end
      if (valid_in && ready && !model_drop(source_in, target_in))
        sb.push_back({source_in, target_in, data_in});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_in = 1'b0; fwd_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    int n = 0;
    source_in = s; target_in = t; data_in = d; valid_in = 1'b1;
    while (!ready && n < 50) begin step(); n++; end
    if (!ready) begin
      ntests++; nfail++; $display("FAIL send_timeout: ready got %b want 1", ready);
    end else step();
    valid_in = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    fwd_ready = 1'b1;
    while (fwd_valid && n < 64) begin step(); n++; end
    fwd_ready = 1'b0;
    ntests++;
    if (fwd_valid !== 1'b0 || sb.size() != 0) begin
      nfail++; $display("FAIL drain: fwd_valid got %b want 0, sb left %0d want 0", fwd_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    ntests++; if (ready !== 1'b1) begin nfail++; $display("FAIL rst_ready: got %b want 1", ready); end
    ntests++; if (fwd_valid !== 1'b0) begin nfail++; $display("FAIL rst_fwd_valid: got %b want 0", fwd_valid); end
    ntests++; if (count !== '0) begin nfail++; $display("FAIL rst_count: got %0d want 0", count); end
    ntests++; if (drop_cnt !== 8'd0) begin nfail++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single();
    fwd_ready = 1'b1;
    send(4'b0001, 4'b0100, 8'hA5);
    ntests++; if (fwd_valid !== 1'b1) begin nfail++; $display("FAIL single_valid: got %b want 1", fwd_valid); end
    ntests++;
    if ({fwd_source, fwd_target, fwd_data} !== 16'h14A5) begin
      nfail++; $display("FAIL single_fields: got %h want 14a5", {fwd_source, fwd_target, fwd_data});
    end
    step();
    fwd_ready = 1'b0;
    ntests++; if (count !== '0) begin nfail++; $display("FAIL single_count: got %0d want 0", count); end
    ntests++; if (fwd_valid !== 1'b0) begin nfail++; $display("FAIL single_empty: got %b want 0", fwd_valid); end
  endtask

  task automatic test_full();
    int n;
    fwd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'b0001, 4'b0100, 8'(i));
    ntests++; if (ready !== 1'b0) begin nfail++; $display("FAIL full_ready: got %b want 0", ready); end
    ntests++; if (count !== 3'd4) begin nfail++; $display("FAIL full_count: got %0d want 4", count); end
    source_in = 4'b0001; target_in = 4'b0100; data_in = 8'h05; valid_in = 1'b1;
    step(); step();
    ntests++; if (count !== 3'd4) begin nfail++; $display("FAIL full_stall_count: got %0d want 4", count); end
    fwd_ready = 1'b1;
    step();
    fwd_ready = 1'b0;
    ntests++; if (ready !== 1'b1) begin nfail++; $display("FAIL full_ready_rise: got %b want 1", ready); end
    ntests++; if (count !== 3'd3) begin nfail++; $display("FAIL full_after_pop: got %0d want 3", count); end
    step();
    valid_in = 1'b0;
    ntests++; if (count !== 3'd4) begin nfail++; $display("FAIL full_fifth_acc: got %0d want 4", count); end
    drain(n);
    ntests++; if (n != 4) begin nfail++; $display("FAIL full_drain_n: got %0d want 4", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    fwd_ready = 1'b0;
    send(4'b0001, 4'b1000, 8'h10);
    send(4'b0001, 4'b1000, 8'h11);
    fwd_ready = 1'b1; valid_in = 1'b1; source_in = 4'b0001; target_in = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'h20 + 8'(i);
      step();
      ntests++;
      if (count !== 3'd2 || ready !== 1'b1) begin
        nfail++; $display("FAIL b2b_steady[%0d]: count %0d ready %b want count 2 ready 1", i, count, ready);
      end
    end
    valid_in = 1'b0;
    drain(n);
    ntests++; if (n != 2) begin nfail++; $display("FAIL b2b_drain_n: got %0d want 2", n); end
  endtask

  task automatic test_filter();
    int n;
    int exp_n;
    logic [7:0] exp_drop;
`ifdef PORT_INGRESS_FILTER_EN
    exp_n = 1; exp_drop = 8'd3;
`else
    exp_n = 4; exp_drop = 8'd0;
`endif
    do_reset();
    send(4'b0001, 4'b0011, 8'h31);
    send(4'b0001, 4'b0001, 8'h32);
    send(4'b0010, 4'b0100, 8'h33);
    send(4'b0001, 4'b0100, 8'h34);
    ntests++; if (drop_cnt !== exp_drop) begin nfail++; $display("FAIL filt_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    ntests++; if (count !== CW'(exp_n)) begin nfail++; $display("FAIL filt_count: got %0d want %0d", count, exp_n); end
    drain(n);
    ntests++; if (n != exp_n) begin nfail++; $display("FAIL filt_out_n: got %0d want %0d", n, exp_n); end
  endtask

  task automatic test_saturate();
    int n;
    logic [7:0] exp_drop;
`ifdef PORT_INGRESS_FILTER_EN
    exp_drop = 8'd255;
`else
    exp_drop = 8'd0;
`endif
    do_reset();
    fwd_ready = 1'b1; valid_in = 1'b1; source_in = 4'b0010; target_in = 4'b0100;
    for (int i = 0; i < 300; i++) begin
      data_in = 8'(i);
      step();
    end
    valid_in = 1'b0;
    ntests++; if (drop_cnt !== exp_drop) begin nfail++; $display("FAIL sat_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
    ntests++; if (ready !== 1'b1) begin nfail++; $display("FAIL sat_ready: got %b want 1", ready); end
    drain(n);
  endtask

  task automatic test_reset_mid();
    do_reset();
`ifdef PORT_INGRESS_FILTER_EN
    send(4'b0100, 4'b0100, 8'hEE);
`endif
    for (int i = 0; i < 3; i++) send(4'b0001, 4'b0100, 8'h40 + 8'(i));
    ntests++; if (count !== 3'd3) begin nfail++; $display("FAIL mid_pre_count: got %0d want 3", count); end
    source_in = 4'b0001; target_in = 4'b0100; data_in = 8'h4F; valid_in = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1; valid_in = 1'b0;
    ntests++; if (count !== '0) begin nfail++; $display("FAIL mid_count: got %0d want 0", count); end
    ntests++; if (fwd_valid !== 1'b0) begin nfail++; $display("FAIL mid_fwd_valid: got %b want 0", fwd_valid); end
    ntests++; if (ready !== 1'b1) begin nfail++; $display("FAIL mid_ready: got %b want 1", ready); end
    ntests++; if (drop_cnt !== 8'd0) begin nfail++; $display("FAIL mid_drop_cnt: got %0d want 0", drop_cnt); end
    step();
    ntests++; if (fwd_valid !== 1'b0 || count !== '0) begin
      nfail++; $display("FAIL mid_not_stored: fwd_valid %b count %0d want 0 0", fwd_valid, count);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_filter();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time got %0t want finish earlier", $time);
    $fatal(1);
  end
endmodule
